ndp_axis_tx: RTL and testbench

- AXI4-Stream master that streams a job's operand words out of a local synchronous-read RAM into the NDP core's 32-bit slave stream port.
- Sits on the host/DMA side, in front of the core's s_axis_* interface. It is the transmitter for that receiver.
- A job is (base address, word count). The block drives tlast on the final word, which ends the core's layer.
- A small 2-entry output FIFO hides RAM read latency and absorbs tready backpressure without losing throughput.

---
 rtl/ndp_pkg.sv | 18 +
 rtl/ndp_axis_tx_if.sv | 14 +
 rtl/ndp_axis_fifo2.sv | 60 ++++++
 rtl/ndp_axis_tx.sv | 124 ++++++++++++
 tb/tb_ndp_axis_tx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ndp_pkg.sv
// Shared types for the NDP stream transmitter: word width, stream beat and FSM states.
package ndp_pkg;

  localparam int unsigned DATA_W = 32;

  // One stream beat as held in the output FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tlast;
  } axis_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/ndp_axis_tx_if.sv
// AXI4-Stream bundle between the transmitter and the NDP core's slave port.
interface ndp_axis_tx_if #(
  parameter int unsigned DATA_W = ndp_pkg::DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ndp_axis_fifo2.sv
// Two-entry FIFO with a registered head; the head drives the stream outputs directly.
module ndp_axis_fifo2
  import ndp_pkg::*;
(
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       push,
  input  axis_beat_t push_beat,
  input  logic       pop,
  output axis_beat_t head,
  output logic [1:0] count,
  output logic       empty,
  output logic       full
);

  axis_beat_t tail;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

  // Head/tail storage and occupancy; push and pop together keep the count.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_beat;
          else               tail <= push_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // With one entry the incoming beat becomes the head directly.
          if (count == 2'd1) begin
            head <= push_beat;
          end else begin
            head <= tail;
            tail <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage must never overflow or underflow.
  always_ff @(posedge axi_aclk) begin
    if (axi_aresetn) begin
      assert (!(push && !pop && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/ndp_axis_tx.sv
// Streams a job's words from a synchronous-read RAM out as an AXI4-Stream master.
module ndp_axis_tx #(
  parameter int unsigned DATA_W     = ndp_pkg::DATA_W,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LEN_W      = 12,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  ndp_axis_tx_if.master     m_axis
);

  import ndp_pkg::*;

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_left;
  logic [LEN_W-1:0]  tx_left;
  logic              inflight;
  logic              inflight_last;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  axis_beat_t        head;
  axis_beat_t        push_beat;

  assign pop       = ~fifo_empty & m_axis.tready;
  // Words buffered or in flight after this cycle's pop; reads stop at FIFO capacity.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_STREAM) && (rd_left != '0) &&
                     (occupancy < 3'(FIFO_DEPTH));

  assign push_beat.tdata = mem_rdata;
  assign push_beat.tlast = inflight_last;

  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = head.tdata;
  assign m_axis.tlast  = head.tlast;

  ndp_axis_fifo2 u_fifo (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .push        (inflight),
    .push_beat   (push_beat),
    .pop         (pop),
    .head        (head),
    .count       (fifo_cnt),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next-state decode and status/RAM outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mem_en    = issue;
    mem_addr  = rd_addr;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_words != '0) ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        if (pop && head.tlast) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Job counters, read address and the in-flight read tracker.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_addr       <= '0;
      rd_left       <= '0;
      tx_left       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rd_left == LEN_W'(1));
      if (state == ST_IDLE && start) begin
        rd_addr <= base_addr;
        rd_left <= num_words;
        tx_left <= num_words;
      end else begin
        if (issue) begin
          rd_addr <= rd_addr + ADDR_W'(1);
          rd_left <= rd_left - LEN_W'(1);
        end
        if (pop) tx_left <= tx_left - LEN_W'(1);
      end
    end
  end

  // tlast must coincide with the final outstanding beat; a returning read always finds room.
  always_ff @(posedge axi_aclk) begin
    if (axi_aresetn) begin
      if (pop) assert (head.tlast == (tx_left == LEN_W'(1)));
      assert (!(inflight && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_ndp_axis_tx.sv
// Bench for ndp_axis_tx: directed and random jobs against a queue-based reference.
module tb_ndp_axis_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] ram [4096];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  ndp_axis_tx_if #(.DATA_W(32)) axis ();

  ndp_axis_tx #(
    .DATA_W     (32),
    .ADDR_W     (12),
    .LEN_W      (12),
    .FIFO_DEPTH (2)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .m_axis      (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_addr"},   mem_addr, 0);
    chk({tag, "_tvalid"}, axis.tvalid, 0);
    chk({tag, "_tlast"},  axis.tlast, 0);
    chk({tag, "_tdata"},  axis.tdata, 0);
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // abort_after: nonzero -> assert reset once that many beats have been accepted.
  // poke_start: pulse start with junk parameters in cycle 4 of the job.
  task automatic run_job(input int unsigned base, input int unsigned num,
                         input int unsigned mode, input int unsigned abort_after,
                         input bit poke_start);
    logic [31:0] expq [$];
    bit          lastq [$];
    int unsigned issued;
    int unsigned popped;
    int unsigned cyc;
    int unsigned first_valid;
    int unsigned budget;
    int          occ;
    bit          fin;
    bit          aborted;
    bit          pop_now;
    bit          was_stall;
    logic [31:0] st_data;
    logic        st_last;
    issued = 0; popped = 0; cyc = 0; first_valid = 0;
    fin = 0; aborted = 0; was_stall = 0; st_data = '0; st_last = 0;
    budget = 60 + num * 12;
    for (int unsigned k = 0; k < num; k++) begin
      expq.push_back(ram[(base + k) % 4096]);
      lastq.push_back(k == num - 1);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = 12'(base);
    num_words = 12'(num);
    axis.tready = 1'b1;

    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start     = poke_start && (cyc == 4);
      base_addr = 12'($urandom);
      num_words = 12'($urandom);
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ((cyc - 1) % 3 == 0);
        default: axis.tready = ($urandom_range(0, 3) != 0);
      endcase
      if (abort_after != 0 && popped == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      #1;
      chk("busy_during_job", busy, 1);
      pop_now = axis.tvalid && axis.tready;
      if (axis.tvalid && first_valid == 0) first_valid = cyc;
      if (was_stall) begin
        chk("stall_tvalid", axis.tvalid, 1);
        chk("stall_tdata",  axis.tdata, st_data);
        chk("stall_tlast",  axis.tlast, st_last);
      end
      if (mem_en) begin
        occ = int'(issued) - int'(popped) - int'(pop_now);
        chk("rd_addr", mem_addr, (base + issued) % 4096);
        chk("rd_room", occ < 2, 1);
        issued++;
      end
      if (pop_now) begin
        if (popped < num) begin
          chk("beat_data", axis.tdata, expq[popped]);
          chk("beat_last", axis.tlast, lastq[popped]);
        end else begin
          chk("extra_beat", popped, num);
        end
        popped++;
      end
      was_stall = axis.tvalid && !axis.tready;
      st_data   = axis.tdata;
      st_last   = axis.tlast;
      if (done) fin = 1;
    end

    if (aborted) return;
    chk("job_finished", fin, 1);
    if (!fin) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      return;
    end
    chk("beat_count", popped, num);
    chk("read_count", issued, num);
    if (mode == 0) begin
      chk("done_cycle", cyc, (num == 0) ? 1 : num + 3);
      if (num != 0) chk("first_valid_cycle", first_valid, 3);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_busy",   busy, 0);
    chk("idle_done",   done, 0);
    chk("idle_tvalid", axis.tvalid, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    axis.tready = 1'b1;
    for (int i = 0; i < 4096; i++) ram[i] = 32'(i) + 32'h100;
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_job(0, 4, 0, 0, 0);
    run_job(0, 5, 1, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(12'hFFE, 4, 0, 0, 0);
    run_job(7, 1, 0, 0, 0);
    run_job(0, 8, 0, 2, 0);
    run_job(0, 3, 0, 0, 0);
    run_job(16, 6, 1, 0, 1);

    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    for (int j = 0; j < 10; j++) begin
      int unsigned b;
      int unsigned n;
      b = (j == 0) ? 4090 : $urandom_range(0, 4095);
      n = $urandom_range(0, 24);
      run_job(b, n, 2, 0, n >= 2);
    end
    run_job($urandom_range(0, 4095), 20, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
